// File: rtl/sm4_round_engine.sv
// Iterative SM4 cipher engine: 32 rounds on one 128-bit block, ROUNDS_PER_CYCLE rounds per clock.
// Optional macro SM4_KEY_LATCH_EN captures rk_flat at acceptance instead of reading it live.
module sm4_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode_dec,
    input  logic [127:0]  data_in,
    input  logic [1023:0] rk_flat,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  data_out,
    output logic          busy
);

    generate
        if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
            ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16 && ROUNDS_PER_CYCLE != 32) begin : g_bad_rounds
            $error("sm4_round_engine: ROUNDS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    // STEP truncates to 0 for 32 rounds per cycle, so the counter simply stays at 0.
    localparam logic [4:0] STEP  = 5'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] STEP6 = 6'(ROUNDS_PER_CYCLE);

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [127:0]  x_q;
    logic          dec_q;
    logic [4:0]    ctr_q;
    logic [127:0]  data_q;
    logic [127:0]  chain;
    logic [127:0]  result;
    logic          last_step;
    logic          accept;
    logic [1023:0] rk_src;

    // Entry 0 sits in the top byte, so byte b lives at offset 8*(255-b) = {~b, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] trans_enc(input logic [31:0] a);
        logic [31:0] b;
        b = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
        return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^
               {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    endfunction

`ifdef SM4_KEY_LATCH_EN
    logic [1023:0] rk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rk_q <= '0;
        end else if (accept) begin
            rk_q <= rk_flat;
        end
    end

    assign rk_src = rk_q;
`else
    assign rk_src = rk_flat;
`endif

    // Chain ROUNDS_PER_CYCLE rounds; decryption walks the key schedule backwards.
    always_comb begin
        logic [4:0]  idx;
        logic [31:0] rk_word;
        logic [31:0] t_in;
        chain   = x_q;
        idx     = '0;
        rk_word = '0;
        t_in    = '0;
        for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
            idx = ctr_q + 5'(j);
            if (dec_q) begin
                idx = 5'd31 - idx;
            end
            rk_word = rk_src[{idx, 5'b00000} +: 32];
            t_in    = chain[95:64] ^ chain[63:32] ^ chain[31:0] ^ rk_word;
            chain   = {chain[95:0], chain[127:96] ^ trans_enc(t_in)};
        end
    end

    assign result    = {chain[31:0], chain[63:32], chain[95:64], chain[127:96]};
    assign last_step = ({1'b0, ctr_q} + STEP6) == 6'd32;
    assign accept    = in_ready & in_valid;
    assign data_out  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs come from the state register only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= '0;
            dec_q  <= 1'b0;
            ctr_q  <= '0;
            data_q <= '0;
        end else if (accept) begin
            x_q   <= data_in;
            dec_q <= mode_dec;
            ctr_q <= '0;
        end else if (state_q == RUN) begin
            x_q   <= chain;
            ctr_q <= ctr_q + STEP;
            if (last_step) begin
                data_q <= result;
            end
        end
    end

endmodule

// File: tb/tb_sm4_round_engine.sv
// Self-checking bench for sm4_round_engine: one instance per legal ROUNDS_PER_CYCLE, instance 0 (R=1) is the main DUT.
// Honours SM4_KEY_LATCH_EN to exercise the latched-key behaviour.
module tb_sm4_round_engine;

    localparam int NUM_R      = 6;
    localparam int MAIN_LAT   = 32;
    localparam int PERIOD     = MAIN_LAT + 2;
    localparam int NUM_BLOCKS = 500;
    localparam int WAIT_LIMIT = 200;

    localparam logic [127:0] KEY_STD = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT_STD  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT_STD  = 128'h681edf34d206965e86b3e94f536e4246;

    localparam logic [2047:0] SBOX_TB = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             mode_dec;
    logic             out_ready;
    logic [127:0]     data_in;
    logic [1023:0]    rk_flat;
    logic [NUM_R-1:0] in_ready_v;
    logic [NUM_R-1:0] out_valid_v;
    logic [NUM_R-1:0] busy_v;
    logic [127:0]     data_out_v [NUM_R];

    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [127:0]     data_out;

    int               cyc = 0;
    int               n_compared = 0;
    int               n_mismatched = 0;
    logic [127:0]     exp_q [$];
    logic [1023:0]    rk_std;

    for (genvar k = 0; k < NUM_R; k++) begin : g_dut
        sm4_round_engine #(.ROUNDS_PER_CYCLE(1 << k)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[k]),
            .mode_dec  (mode_dec),
            .data_in   (data_in),
            .rk_flat   (rk_flat),
            .out_valid (out_valid_v[k]),
            .out_ready (out_ready),
            .data_out  (data_out_v[k]),
            .busy      (busy_v[k])
        );
    end

    assign in_ready  = in_ready_v[0];
    assign out_valid = out_valid_v[0];
    assign busy      = busy_v[0];
    assign data_out  = data_out_v[0];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference SM4 model, used for key expansion and random-block expectations.
    function automatic logic [31:0] rotl(input logic [31:0] a, input int n);
        return (a << n) | (a >> (32 - n));
    endfunction

    function automatic logic [31:0] tau_tb(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX_TB[8*(255 - int'(a[8*i +: 8])) +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] a);
        logic [31:0] b;
        b = tau_tb(a);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] a);
        logic [31:0] b;
        b = tau_tb(a);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    function automatic logic [1023:0] expand_key(input logic [127:0] mk);
        logic [31:0]   kw [36];
        logic [31:0]   fk [4];
        logic [31:0]   ck;
        logic [1023:0] rk;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        rk = '0;
        ck = '0;
        for (int i = 0; i < 4; i++) begin
            kw[i] = mk[127 - 32*i -: 32] ^ fk[i];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                ck[31 - 8*j -: 8] = 8'((4*i + j) * 7);
            end
            kw[i+4] = kw[i] ^ t_key(kw[i+1] ^ kw[i+2] ^ kw[i+3] ^ ck);
            rk[32*i +: 32] = kw[i+4];
        end
        return rk;
    endfunction

    function automatic logic [127:0] model_crypt(input logic [127:0] d, input logic [1023:0] rk,
                                                 input logic dec);
        logic [31:0] x [36];
        logic [31:0] kword;
        for (int i = 0; i < 4; i++) begin
            x[i] = d[127 - 32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            kword = dec ? rk[32*(31 - i) +: 32] : rk[32*i +: 32];
            x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ kword);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [1023:0] rand1024();
        logic [1023:0] r;
        for (int w = 0; w < 32; w++) begin
            r[32*w +: 32] = $urandom();
        end
        return r;
    endfunction

    // Drive one block; returns at the negedge after the acceptance edge with that edge's cycle number.
    task automatic send_block(input logic [127:0] d, input logic [1023:0] rk, input logic dec,
                              output int acc_cyc);
        int n = 0;
        while (!in_ready && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        data_in  = d;
        rk_flat  = rk;
        mode_dec = dec;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic wait_result(output logic [127:0] got, output int done_cyc);
        int n = 0;
        while (!out_valid && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL result_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
        end
        got      = data_out;
        done_cyc = cyc;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        in_valid  = 1'b0;
        mode_dec  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        rk_flat   = '0;
        rst       = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        n_compared++;
        if (in_ready_v !== '1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b, required all ones", in_ready_v);
        end
        n_compared++;
        if (out_valid_v !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_out_valid: got %b, required zero", out_valid_v);
        end
        n_compared++;
        if (busy_v !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_busy: got %b, required zero", busy_v);
        end
        for (int k = 0; k < NUM_R; k++) begin
            n_compared++;
            if (data_out_v[k] !== 128'h0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_data_out R=%0d: got %h, required 0", 1 << k, data_out_v[k]);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_idle: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_encrypt_vector();
        logic [127:0]     got [NUM_R];
        int               lat [NUM_R];
        logic [NUM_R-1:0] seen;
        logic [127:0]     expected;
        int               acc;
        $display("[TB] test_encrypt_vector");
        out_ready = 1'b0;
        seen      = '0;
        for (int k = 0; k < NUM_R; k++) begin
            got[k] = '0;
            lat[k] = -1;
        end
        exp_q.push_back(CT_STD);
        send_block(PT_STD, rk_std, 1'b0, acc);
        for (int n = 0; n < WAIT_LIMIT && seen != '1; n++) begin
            @(negedge clk);
            for (int k = 0; k < NUM_R; k++) begin
                if (!seen[k] && out_valid_v[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = cyc - acc;
                    got[k]  = data_out_v[k];
                end
            end
        end
        expected = exp_q.pop_front();
        for (int k = 0; k < NUM_R; k++) begin
            n_compared++;
            if (got[k] !== expected) begin
                n_mismatched++;
                $display("[TB] FAIL enc_vector_data R=%0d: got %h, required %h", 1 << k, got[k], expected);
            end
            n_compared++;
            if (lat[k] != (32 >> k)) begin
                n_mismatched++;
                $display("[TB] FAIL enc_vector_latency R=%0d: got %0d, required %0d", 1 << k, lat[k], 32 >> k);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_decrypt_vector();
        logic [127:0] got;
        logic [127:0] expected;
        int           acc;
        int           done_cyc;
        $display("[TB] test_decrypt_vector");
        out_ready = 1'b0;
        exp_q.push_back(PT_STD);
        send_block(CT_STD, rk_std, 1'b1, acc);
        wait_result(got, done_cyc);
        expected = exp_q.pop_front();
        n_compared++;
        if (got !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL dec_vector_data: got %h, required %h", got, expected);
        end
        n_compared++;
        if (done_cyc - acc != MAIN_LAT) begin
            n_mismatched++;
            $display("[TB] FAIL dec_vector_latency: got %0d, required %0d", done_cyc - acc, MAIN_LAT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [127:0] got;
        logic [127:0] expected;
        int           acc;
        int           done_cyc;
        $display("[TB] test_backpressure");
        out_ready = 1'b0;
        exp_q.push_back(CT_STD);
        send_block(PT_STD, rk_std, 1'b0, acc);
        wait_result(got, done_cyc);
        expected = exp_q.pop_front();
        n_compared++;
        if (got !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_data: got %h, required %h", got, expected);
        end
        for (int i = 0; i < 50; i++) begin
            in_valid = (i % 3 == 0);
            data_in  = rand128();
            mode_dec = 1'(i & 1);
            @(negedge clk);
            n_compared++;
            if (out_valid !== 1'b1 || data_out !== expected || in_ready !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b data_out=%h, required 1 0 %h",
                         i, out_valid, in_ready, data_out, expected);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        n_compared++;
        if (busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL backpressure_no_accept: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [127:0] got;
        logic [127:0] expected;
        int           acc;
        int           done_cyc;
        logic         saw_valid;
        $display("[TB] test_reset_mid_run");
        out_ready = 1'b1;
        send_block(PT_STD, rk_std, 1'b0, acc);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        n_compared++;
        if (out_valid !== 1'b0 || data_out !== 128'h0) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_reset_outputs: out_valid=%b data_out=%h, required 0 0", out_valid, data_out);
        end
        n_compared++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_reset_state: in_ready=%b busy=%b, required 1 0", in_ready, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        n_compared++;
        if (saw_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_discard: out_valid pulse seen=%b, required 0", saw_valid);
        end
        exp_q.push_back(CT_STD);
        send_block(PT_STD, rk_std, 1'b0, acc);
        wait_result(got, done_cyc);
        expected = exp_q.pop_front();
        n_compared++;
        if (got !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_fresh_encrypt: got %h, required %h", got, expected);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0]  pt;
        logic [127:0]  ct;
        logic [127:0]  got;
        logic [127:0]  expected;
        logic [1023:0] rk;
        int            acc;
        int            prev_acc;
        int            done_cyc;
        $display("[TB] test_back_to_back");
        out_ready = 1'b1;
        prev_acc  = -1;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            pt = rand128();
            rk = rand1024();
            ct = model_crypt(pt, rk, 1'b0);
            exp_q.push_back(ct);
            send_block(pt, rk, 1'b0, acc);
            if (prev_acc >= 0) begin
                n_compared++;
                if (acc - prev_acc != PERIOD) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_period_enc block %0d: got %0d, required %0d", b, acc - prev_acc, PERIOD);
                end
            end
            prev_acc = acc;
            wait_result(got, done_cyc);
            expected = exp_q.pop_front();
            n_compared++;
            if (got !== expected) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_encrypt block %0d: got %h, required %h", b, got, expected);
            end
            exp_q.push_back(pt);
            send_block(ct, rk, 1'b1, acc);
            n_compared++;
            if (acc - prev_acc != PERIOD) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_period_dec block %0d: got %0d, required %0d", b, acc - prev_acc, PERIOD);
            end
            prev_acc = acc;
            wait_result(got, done_cyc);
            expected = exp_q.pop_front();
            n_compared++;
            if (got !== expected) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_roundtrip block %0d: got %h, required %h", b, got, expected);
            end
        end
    endtask

`ifdef SM4_KEY_LATCH_EN
    task automatic test_key_latch();
        logic [127:0] got;
        logic [127:0] expected;
        int           acc;
        int           n;
        $display("[TB] test_key_latch");
        out_ready = 1'b1;
        exp_q.push_back(CT_STD);
        send_block(PT_STD, rk_std, 1'b0, acc);
        n = 0;
        while (!out_valid && n < WAIT_LIMIT) begin
            rk_flat = rand1024();
            @(negedge clk);
            n++;
        end
        got      = data_out;
        expected = exp_q.pop_front();
        n_compared++;
        if (out_valid !== 1'b1 || got !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL key_latch: out_valid=%b data_out=%h, required 1 %h", out_valid, got, expected);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rk_std = expand_key(KEY_STD);
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SM4_KEY_LATCH_EN
        test_key_latch();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
